// File: rtl/ifft8_pkg.sv
// Shared constants for the sequential 8-point inverse FFT: formats, conjugate
// twiddles, bit-reverse load order and the controller state encoding.
package ifft8_pkg;

    localparam int DEF_DW   = 16;
    localparam int DEF_FRAC = 8;

    // W8^-k in Q8.8, k = 0..3
    localparam int TW_RE [4] = '{256, 181, 0, -181};
    localparam int TW_IM [4] = '{0, 181, 256, 181};

    localparam logic [2:0] BITREV [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    typedef enum logic [2:0] {
        IDLE,
        ST1,
        ST2,
        ST3,
        OUT
    } state_t;

endpackage

// File: rtl/ifft8_seq_bfly.sv
// Combinational radix-2 complex butterfly: y1 = x1 + x2*w, y2 = x1 - x2*w,
// optional halving, wrapped back to DW bits.
module ifft_bfly #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic signed [DW-1:0] x1_re,
    input  logic signed [DW-1:0] x1_im,
    input  logic signed [DW-1:0] x2_re,
    input  logic signed [DW-1:0] x2_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    input  logic                 scale_en,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im,
    output logic signed [DW-1:0] y2_re,
    output logic signed [DW-1:0] y2_im
);

    logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*DW:0]   prod_re, prod_im;
    logic signed [DW+1:0]   t_re, t_im, a_re, a_im;
    logic signed [DW+1:0]   s1_re, s1_im, s2_re, s2_im;

    assign p_rr = x2_re * w_re;
    assign p_ii = x2_im * w_im;
    assign p_ri = x2_re * w_im;
    assign p_ir = x2_im * w_re;

    assign prod_re = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
    assign prod_im = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);

    // |t| never exceeds 2^(DW), so DW+2 bits hold it without loss
    assign t_re = (DW+2)'(prod_re >>> FRAC);
    assign t_im = (DW+2)'(prod_im >>> FRAC);
    assign a_re = (DW+2)'(x1_re);
    assign a_im = (DW+2)'(x1_im);

    assign s1_re = a_re + t_re;
    assign s1_im = a_im + t_im;
    assign s2_re = a_re - t_re;
    assign s2_im = a_im - t_im;

    assign y1_re = DW'(scale_en ? (s1_re >>> 1) : s1_re);
    assign y1_im = DW'(scale_en ? (s1_im >>> 1) : s1_im);
    assign y2_re = DW'(scale_en ? (s2_re >>> 1) : s2_re);
    assign y2_im = DW'(scale_en ? (s2_im >>> 1) : s2_im);

endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: one shared butterfly walks
// 3 stages x 4 butterflies over an in-place, bit-reverse-loaded memory.
module ifft8_seq
    import ifft8_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int FRAC     = DEF_FRAC,
    parameter bit SCALE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic            start,
    input  logic [8*DW-1:0] in_real,
    input  logic [8*DW-1:0] in_imag,
    output logic [8*DW-1:0] out_real,
    output logic [8*DW-1:0] out_imag,
    output logic            busy,
    output logic            ready
);

    state_t state, state_next;
    logic [1:0] bf;
    logic signed [DW-1:0] mem_re [8];
    logic signed [DW-1:0] mem_im [8];
    logic [2:0] idx_a, idx_b;
    logic [1:0] tw_k;
    logic signed [DW-1:0] w_re, w_im;
    logic signed [DW-1:0] y1_re, y1_im, y2_re, y2_im;
    logic idle, computing;

    assign idle      = (state == IDLE);
    assign computing = (state == ST1) || (state == ST2) || (state == ST3);
    assign busy      = !idle;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ST1;
            ST1:     if (bf == 2'd3) state_next = ST2;
            ST2:     if (bf == 2'd3) state_next = ST3;
            ST3:     if (bf == 2'd3) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pair and twiddle selection for span 1, 2, 4
    always_comb begin
        idx_a = '0;
        idx_b = '0;
        tw_k  = '0;
        case (state)
            ST1: begin
                idx_a = {bf, 1'b0};
                idx_b = {bf, 1'b1};
            end
            ST2: begin
                idx_a = {bf[1], 1'b0, bf[0]};
                idx_b = {bf[1], 1'b1, bf[0]};
                tw_k  = {bf[0], 1'b0};
            end
            ST3: begin
                idx_a = {1'b0, bf};
                idx_b = {1'b1, bf};
                tw_k  = bf;
            end
            default: ;
        endcase
    end

    assign w_re = DW'(TW_RE[tw_k]);
    assign w_im = DW'(TW_IM[tw_k]);

    ifft_bfly #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_bfly (
        .x1_re    (mem_re[idx_a]),
        .x1_im    (mem_im[idx_a]),
        .x2_re    (mem_re[idx_b]),
        .x2_im    (mem_im[idx_b]),
        .w_re     (w_re),
        .w_im     (w_im),
        .scale_en (SCALE_EN),
        .y1_re    (y1_re),
        .y1_im    (y1_im),
        .y2_re    (y2_re),
        .y2_im    (y2_im)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            bf       <= '0;
            ready    <= 1'b0;
            out_real <= '0;
            out_imag <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            if (computing) bf <= bf + 2'd1;
            else           bf <= '0;

            if (idle && write) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    mem_re[i] <= in_real[int'(BITREV[i])*DW +: DW];
                    mem_im[i] <= in_imag[int'(BITREV[i])*DW +: DW];
                end
            end

            if (computing) begin
                mem_re[idx_a] <= y1_re;
                mem_im[idx_a] <= y1_im;
                mem_re[idx_b] <= y2_re;
                mem_im[idx_b] <= y2_im;
            end

            if (idle && (write || start)) begin
                ready <= 1'b0;
            end else if (state == OUT) begin
                ready <= 1'b1;
                for (int unsigned i = 0; i < 8; i++) begin
                    out_real[i*DW +: DW] <= mem_re[i];
                    out_imag[i*DW +: DW] <= mem_im[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft8_seq.sv
// Self-checking bench for ifft8_seq: directed spectra with known time-domain
// results, randomized spectra against a stage-loop model, and control hazards.
module tb_ifft8_seq;

    localparam int DW = 16;

    typedef logic [7:0][15:0] vec8_t;
    typedef struct packed {
        vec8_t      xr;
        vec8_t      xi;
        vec8_t      er;
        vec8_t      ei;
        logic [3:0] tol;
    } dvec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            write = 1'b0;
    logic            start = 1'b0;
    logic [8*DW-1:0] in_real = '0;
    logic [8*DW-1:0] in_imag = '0;
    logic [8*DW-1:0] out_real;
    logic [8*DW-1:0] out_imag;
    logic            busy;
    logic            ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifft8_seq #(
        .DW       (16),
        .FRAC     (8),
        .SCALE_EN (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .start    (start),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .out_real (out_real),
        .out_imag (out_imag),
        .busy     (busy),
        .ready    (ready)
    );

    function automatic longint wrap16(input longint v);
        logic [15:0] b;
        b = v[15:0];
        return longint'($signed(b));
    endfunction

    // Textbook DIT loop: bit-reversed load, spans 1,2,4, twiddle W8^-(j*4/span)
    task automatic ref_ifft(input vec8_t xr, input vec8_t xi, input bit scale,
                            output vec8_t yr, output vec8_t yi);
        longint ar [8];
        longint ai [8];
        int wr_t [4] = '{256, 181, 0, -181};
        int wi_t [4] = '{0, 181, 256, 181};
        for (int n = 0; n < 8; n++) begin
            int r;
            r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            ar[n] = longint'($signed(xr[r]));
            ai[n] = longint'($signed(xi[r]));
        end
        for (int span = 1; span < 8; span = span * 2) begin
            for (int g = 0; g < 8; g += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    int a, b, k;
                    longint tr, ti, u1r, u1i, u2r, u2i;
                    a = g + j;
                    b = a + span;
                    k = j * (4 / span);
                    tr = (ar[b] * wr_t[k] - ai[b] * wi_t[k]) >>> 8;
                    ti = (ar[b] * wi_t[k] + ai[b] * wr_t[k]) >>> 8;
                    u1r = ar[a] + tr;  u1i = ai[a] + ti;
                    u2r = ar[a] - tr;  u2i = ai[a] - ti;
                    if (scale) begin
                        u1r = u1r >>> 1;  u1i = u1i >>> 1;
                        u2r = u2r >>> 1;  u2i = u2i >>> 1;
                    end
                    ar[a] = wrap16(u1r);  ai[a] = wrap16(u1i);
                    ar[b] = wrap16(u2r);  ai[b] = wrap16(u2i);
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            yr[n] = ar[n][15:0];
            yi[n] = ai[n][15:0];
        end
    endtask

    task automatic check_val(input string name, input int idx, input longint act,
                             input longint exp, input int tol);
        n_cmp++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (tol %0d)", name, idx, act, exp, tol);
        end
    endtask

    task automatic check_outputs(input string name, input vec8_t er, input vec8_t ei, input int tol);
        for (int k = 0; k < 8; k++) begin
            check_val({name, ".re"}, k, longint'($signed(out_real[k*DW +: DW])),
                      longint'($signed(er[k])), tol);
            check_val({name, ".im"}, k, longint'($signed(out_imag[k*DW +: DW])),
                      longint'($signed(ei[k])), tol);
        end
    endtask

    task automatic drive(input logic wr, input logic st, input vec8_t xr, input vec8_t xi);
        @(negedge clk);
        write   = wr;
        start   = st;
        in_real = xr;
        in_imag = xi;
        @(posedge clk);
        #1;
        write = 1'b0;
        start = 1'b0;
    endtask

    // Called #1 after the start edge plus lat0 edges; lat counts edges from start
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = busy ? 1 : 0;
        while (!ready && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    function automatic vec8_t rand_vec();
        vec8_t v;
        for (int k = 0; k < 8; k++) v[k] = 16'($urandom());
        return v;
    endfunction

    dvec_t tbl [4];
    vec8_t zero_v, vr, vi, er, ei, jr, ji;
    int    lat, bcnt;

    initial begin
        zero_v = '0;

        // Reset held for two cycles under random activity
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            write   = 1'($urandom());
            start   = 1'($urandom());
            in_real = rand_vec();
            in_imag = rand_vec();
        end
        @(posedge clk);
        #1;
        check_val("rst.out_real_nz", 0, longint'(out_real != '0), 0, 0);
        check_val("rst.out_imag_nz", 0, longint'(out_imag != '0), 0, 0);
        check_val("rst.busy", 0, longint'(busy), 0, 0);
        check_val("rst.ready", 0, longint'(ready), 0, 0);
        @(negedge clk);
        rst = 1'b1; write = 1'b0; start = 1'b0;

        // Directed vectors
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        tbl[0].xr[0] = 16'sd256;
        for (int k = 0; k < 8; k++) tbl[0].er[k] = 16'sd32;
        for (int k = 0; k < 8; k++) tbl[1].xr[k] = 16'sd256;
        tbl[1].er[0] = 16'sd256;
        tbl[2].xr[1] = 16'sd2048;
        tbl[2].tol   = 4'd2;
        tbl[2].er = {16'sd181, 16'sd0, -16'sd181, -16'sd256, -16'sd181, 16'sd0, 16'sd181, 16'sd256};
        tbl[2].ei = {-16'sd181, -16'sd256, -16'sd181, 16'sd0, 16'sd181, 16'sd256, 16'sd181, 16'sd0};
        tbl[3].xr[2] = 16'sd2048;
        tbl[3].tol   = 4'd2;
        tbl[3].er = {16'sd0, -16'sd256, 16'sd0, 16'sd256, 16'sd0, -16'sd256, 16'sd0, 16'sd256};
        tbl[3].ei = {-16'sd256, 16'sd0, 16'sd256, 16'sd0, -16'sd256, 16'sd0, 16'sd256, 16'sd0};

        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                drive(1'b1, 1'b1, tbl[i].xr, tbl[i].xi);
            end else begin
                drive(1'b1, 1'b0, tbl[i].xr, tbl[i].xi);
                if (i == 3) begin
                    check_val("b2b.ready_after_write", 0, longint'(ready), 0, 0);
                    check_outputs("b2b.hold", tbl[2].er, tbl[2].ei, 2);
                end
                drive(1'b0, 1'b1, zero_v, zero_v);
            end
            wait_done(0, lat, bcnt);
            check_val("dir.latency", i, lat, 13, 0);
            check_val("dir.busy_cycles", i, bcnt, 13, 0);
            check_outputs($sformatf("dir%0d", i), tbl[i].er, tbl[i].ei, int'(tbl[i].tol));
        end

        // Random spectra against the model
        for (int r = 0; r < 16; r++) begin
            vr = rand_vec();
            vi = rand_vec();
            ref_ifft(vr, vi, 1'b1, er, ei);
            if (r[0]) begin
                drive(1'b1, 1'b1, vr, vi);
            end else begin
                drive(1'b1, 1'b0, vr, vi);
                drive(1'b0, 1'b1, zero_v, zero_v);
            end
            wait_done(0, lat, bcnt);
            check_val("rnd.latency", r, lat, 13, 0);
            check_outputs($sformatf("rnd%0d", r), er, ei, 0);
        end

        // start+write at E+5 are ignored
        vr = rand_vec(); vi = rand_vec();
        jr = rand_vec(); ji = rand_vec();
        ref_ifft(vr, vi, 1'b1, er, ei);
        drive(1'b1, 1'b0, vr, vi);
        drive(1'b0, 1'b1, zero_v, zero_v);
        repeat (4) @(posedge clk);
        drive(1'b1, 1'b1, jr, ji);
        wait_done(5, lat, bcnt);
        check_val("busy_hazard.latency", 0, lat, 13, 0);
        check_outputs("busy_hazard", er, ei, 0);

        // Reset at E+6 aborts, then a fresh transform completes
        vr = rand_vec(); vi = rand_vec();
        drive(1'b1, 1'b0, vr, vi);
        drive(1'b0, 1'b1, zero_v, zero_v);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort.ready", 0, longint'(ready), 0, 0);
        check_val("abort.busy", 0, longint'(busy), 0, 0);
        check_outputs("abort", zero_v, zero_v, 0);
        @(negedge clk);
        rst = 1'b1;
        vr = rand_vec(); vi = rand_vec();
        ref_ifft(vr, vi, 1'b1, er, ei);
        drive(1'b1, 1'b1, vr, vi);
        wait_done(0, lat, bcnt);
        check_val("after_abort.latency", 0, lat, 13, 0);
        check_outputs("after_abort", er, ei, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
